input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles before a key change is accepted (5 ms at 50 MHz).
REQ-002 Parameter: CNT_W, 18, debounce counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port: clk  input  1  system clock, 50 MHz.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: key_n  input  3  raw active-low push buttons, asynchronous to clk; bit0 right, bit1 jump, bit2 left.
REQ-006 Port: game_tick  input  1  one-cycle 60 Hz game strobe, synchronous to clk.
REQ-007 Port: move_right  output  1  debounced right held, after conflict cancel.
REQ-008 Port: move_left  output  1  debounced left held, after conflict cancel.
REQ-009 Port: jump_level  output  1  debounced jump held.
REQ-010 Port: jump_press  output  1  one-cycle jump-press pulse, asserted only in a game_tick cycle.
REQ-011 Port: any_input_level  output  1  OR of the three debounced keys, before conflict cancel.

Function
REQ-012 Each key_n bit SHALL be inverted and passed through a 2-flop synchronizer; synchronizer flops reset to 0 (released).
REQ-013 Each key SHALL hold a debounced state bit and a CNT_W-bit counter.
REQ-014 When the synced value equals the debounced state, the counter SHALL clear to 0.
REQ-015 When they differ, the counter SHALL increment; in the cycle it equals DEBOUNCE_CYCLES-1, the state SHALL take the synced value and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced state; any bounce back to the stable value restarts the count from 0.
REQ-017 A clean edge on key_n SHALL reach the debounced state exactly 2+DEBOUNCE_CYCLES clk cycles later; move_*, jump_level and any_input_level are registered one cycle after that.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL never wrap.
REQ-019 If left and right are both debounced-pressed, move_left and move_right SHALL both be 0; any_input_level SHALL remain 1.
REQ-020 A 0->1 transition of the debounced jump state SHALL set a pending flag.
REQ-021 In a game_tick cycle with the pending flag set, jump_press SHALL be 1 for that cycle and pending SHALL clear; otherwise jump_press is 0.
REQ-022 A rising edge in the same cycle as game_tick with pending clear SHALL set pending, not pulse; the pulse occurs on the next game_tick.
REQ-023 Further rising edges while pending SHALL be absorbed, so at most one pulse per tick and no press count.
REQ-024 A press released before the next tick SHALL still produce its jump_press pulse.

Reset
REQ-025 Asserting rst SHALL immediately clear all synchronizers, debounced states, counters, the pending flag and all outputs to 0, including mid-debounce and mid-pending.
REQ-026 After rst deasserts with keys held, a press SHALL be reported only after the full REQ-017 latency, and SHALL generate a jump edge.

Structure
REQ-027 A shared package SHALL hold the key index constants (KEY_RIGHT=0, KEY_JUMP=1, KEY_LEFT=2) and the DEBOUNCE_CYCLES default.
REQ-028 One sub-module, key_debouncer (synchronizer, counter and state for one key), SHALL be instantiated three times; edge/pending/cancel logic stays in input_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Test 1: key_n[0] falls and stays low -> move_right=1 exactly 7 cycles later; any_input_level=1 in the same cycle.
REQ-030 Test 2: key_n[1] low for 3 cycles, then high -> jump_level, jump_press and any_input_level stay 0 throughout.
REQ-031 Test 3: jump held 20 cycles with no tick, then one game_tick -> jump_press=1 in that tick cycle only; the next tick gives 0.
REQ-032 Test 4: two debounced jump presses between ticks -> exactly one pulse; debounced rising edge coincident with game_tick -> pulse on the following tick.
REQ-033 Test 5: left and right both held -> move_left=move_right=0 and any_input_level=1; releasing left -> move_right=1 after 7 cycles.
REQ-034 Test 6: rst asserted mid-count and mid-pending -> all outputs 0 immediately; no pulse on the next tick.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: key bit positions and
// default debounce timing for a 50 MHz clock.
package input_conditioner_pkg;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_RIGHT = 0;
  localparam int KEY_JUMP  = 1;
  localparam int KEY_LEFT  = 2;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int CNT_W_DEFAULT           = 18;

endpackage

// File: rtl/key_debouncer.sv
// One push button: active-low raw input is inverted, synchronised and then
// debounced so the state only follows the key after a long enough stable run.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic state_o
);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any bounce back to the accepted state restarts the run from zero, and the
  // counter clears on acceptance, so it never passes DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the three game buttons, cancels opposing left/right, and turns a
// debounced jump press into a single pulse aligned to the 60 Hz game tick.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                game_tick,
  output logic                move_right,
  output logic                move_left,
  output logic                jump_level,
  output logic                jump_press,
  output logic                any_input_level
);

  logic [NUM_KEYS-1:0] db;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .key_n_i(key_n[k]),
      .state_o(db[k])
    );
  end

  logic move_right_q, move_right_d;
  logic move_left_q, move_left_d;
  logic jump_level_q, jump_level_d;
  logic any_q, any_d;
  logic jump_prev_q, jump_rise;
  logic pending_q, pending_d;

  // A tick consumes the pending press first; a rise in that same cycle is
  // absorbed, and a rise with nothing pending waits for the next tick.
  always_comb begin
    move_right_d = db[KEY_RIGHT] & ~db[KEY_LEFT];
    move_left_d  = db[KEY_LEFT] & ~db[KEY_RIGHT];
    jump_level_d = db[KEY_JUMP];
    any_d        = |db;
    jump_rise    = db[KEY_JUMP] & ~jump_prev_q;
    pending_d    = pending_q;
    if (game_tick && pending_q) begin
      pending_d = 1'b0;
    end else if (jump_rise) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_right_q <= 1'b0;
      move_left_q  <= 1'b0;
      jump_level_q <= 1'b0;
      any_q        <= 1'b0;
      jump_prev_q  <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      move_right_q <= move_right_d;
      move_left_q  <= move_left_d;
      jump_level_q <= jump_level_d;
      any_q        <= any_d;
      jump_prev_q  <= db[KEY_JUMP];
      pending_q    <= pending_d;
    end
  end

  assign move_right      = move_right_q;
  assign move_left       = move_left_q;
  assign jump_level      = jump_level_q;
  assign any_input_level = any_q;
  assign jump_press      = game_tick & pending_q;

endmodule
